// File: rtl/shift_arb_seq_pkg.sv
// rtl/shift_arb_seq_pkg.sv - shared op/state encodings and counter sizing for shift_arb_seq
package shift_arb_seq_pkg;

    typedef enum logic [1:0] {
        OP_SRA  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SLL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must hold the value N itself, hence one bit beyond log2(N).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_arb_seq_shift_step.sv
// rtl/shift_arb_seq_shift_step.sv - combinational one-bit shift selected by op
module shift_step
    import shift_arb_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [1:0]   op,
    output logic [N-1:0] y
);

    always_comb begin
        y = a;
        case (op_e'(op))
            OP_SRA:  y = {a[N-1], a[N-1:1]};
            OP_SRL:  y = {1'b0, a[N-1:1]};
            OP_SLL:  y = {a[N-2:0], 1'b0};
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/shift_arb_seq.sv
// rtl/shift_arb_seq.sv - two-requester round-robin arbiter feeding a bit-serial shifter
module shift_arb_seq
    import shift_arb_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_out,
    output logic         rsp_id
);

    localparam int CW = cnt_width(N);
    localparam logic [N-1:0]  B_SAT   = N'(N);
    localparam logic [CW-1:0] CNT_SAT = CW'(N);

    state_e        state_q, state_d;
    logic          ptr_q;
    logic [N-1:0]  acc_q;
    op_e           op_q;
    logic          id_q;
    logic [CW-1:0] cnt_q;

    logic          grant0, grant1, accept, sel_id;
    logic [N-1:0]  sel_a, sel_b;
    op_e           sel_op;
    logic [CW-1:0] sel_cnt;
    logic [N-1:0]  step_out;

    // Pointed requester has priority; the other wins only when the pointed one is idle.
    always_comb begin
        grant0     = req0_valid && (!ptr_q || !req1_valid);
        grant1     = req1_valid && ( ptr_q || !req0_valid);
        req0_ready = rst_n && (state_q == ST_IDLE) && grant0;
        req1_ready = rst_n && (state_q == ST_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel_id     = req1_ready;
    end

    always_comb begin
        sel_a   = sel_id ? req1_a : req0_a;
        sel_b   = sel_id ? req1_b : req0_b;
        sel_op  = op_e'(sel_id ? req1_op : req0_op);
        sel_cnt = '0;
        // Clamping at N makes large amounts saturate naturally through the shifter.
        if (sel_op == OP_PASS) begin
            sel_cnt = '0;
        end else if (sel_b >= B_SAT) begin
            sel_cnt = CNT_SAT;
        end else begin
            sel_cnt = sel_b[CW-1:0];
        end
    end

    shift_step #(.N(N)) u_shift_step (
        .a  (acc_q),
        .op (op_q),
        .y  (step_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (sel_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            acc_q   <= '0;
            op_q    <= OP_SRA;
            id_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc_q <= sel_a;
                        op_q  <= sel_op;
                        id_q  <= sel_id;
                        cnt_q <= sel_cnt;
                        ptr_q <= ~sel_id;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= step_out;
                    cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_out   = acc_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_arb_seq.sv
// tb/tb_shift_arb_seq.sv - directed self-checking bench for shift_arb_seq
module tb_shift_arb_seq;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_out;

    int checks;
    int failures;

    shift_arb_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
        rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                failures++;
                $display("FAIL reset_readys: got %b want 00", {req1_ready, req0_ready});
            end
            checks++;
            if (rsp_valid !== 1'b0 || rsp_out !== 8'h00 || rsp_id !== 1'b0) begin
                failures++;
                $display("FAIL reset_rsp: got valid=%b out=%h id=%b want 0/00/0", rsp_valid, rsp_out, rsp_id);
            end
            cyc();
        end
        apply_reset();
    endtask

    task automatic test_single;
        int n;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h90; req0_b = 8'd3; req0_op = 2'b00;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL single_grant: got %b want 01", {req1_ready, req0_ready});
        end
        cyc();
        req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'b11;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: got ready=%b valid=%b want 0/0", req0_ready, rsp_valid);
        end
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL single_latency: got %0d edges want 3", n);
        end
        checks++;
        if (rsp_out !== 8'hF2 || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL single_result: got out=%h id=%b want F2/0", rsp_out, rsp_id);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_release: got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_alternate;
        logic exp_id;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'd1; req0_op = 2'b01;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'd1; req1_op = 2'b10;
        rsp_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            checks++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL alt_grant[%0d]: got %b want id %0d", i, {req1_ready, req0_ready}, exp_id);
            end
            cyc();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL alt_shift[%0d]: got valid=%b want 0", i, rsp_valid);
            end
            cyc();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_out !== (exp_id ? 8'h06 : 8'h08)) begin
                failures++;
                $display("FAIL alt_rsp[%0d]: got valid=%b id=%b out=%h want 1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_out, exp_id, exp_id ? 8'h06 : 8'h08);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_saturate;
        int n;
        apply_reset();
        for (int j = 0; j < 2; j++) begin
            req1_valid = 1'b1; req1_a = 8'h81; req1_b = 8'd200;
            req1_op = (j == 0) ? 2'b00 : 2'b01;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                failures++;
                $display("FAIL sat_grant[%0d]: got %b want 10", j, {req1_ready, req0_ready});
            end
            cyc();
            req1_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 30) begin
                cyc();
                n++;
            end
            checks++;
            if (n !== 8) begin
                failures++;
                $display("FAIL sat_latency[%0d]: got %0d edges want 8", j, n);
            end
            checks++;
            if (rsp_out !== ((j == 0) ? 8'hFF : 8'h00) || rsp_id !== 1'b1) begin
                failures++;
                $display("FAIL sat_result[%0d]: got out=%h id=%b want %h/1", j, rsp_out, rsp_id,
                         (j == 0) ? 8'hFF : 8'h00);
            end
            rsp_ready = 1'b1;
            cyc();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_pass;
        apply_reset();
        for (int j = 0; j < 2; j++) begin
            req0_valid = 1'b1; req0_a = 8'h5A;
            req0_b  = (j == 0) ? 8'd0 : 8'd5;
            req0_op = (j == 0) ? 2'b10 : 2'b11;
            #1;
            cyc();
            req0_valid = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_out !== 8'h5A || rsp_id !== 1'b0) begin
                failures++;
                $display("FAIL pass[%0d]: got valid=%b out=%h id=%b want 1/5A/0", j, rsp_valid, rsp_out, rsp_id);
            end
            rsp_ready = 1'b1;
            cyc();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int n;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'd2; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'd1; req1_op = 2'b11;
        #1;
        cyc();
        n = 0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL bp_latency: got %0d edges want 2", n);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_out !== 8'h3C || rsp_id !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b out=%h id=%b want 1/3C/0", k, rsp_valid, rsp_out, rsp_id);
            end
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                failures++;
                $display("FAIL bp_readys[%0d]: got %b want 00", k, {req1_ready, req0_ready});
            end
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_next_grant: got %b want 10", {req1_ready, req0_ready});
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        int seen;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'hC0; req0_b = 8'd6; req0_op = 2'b01;
        #1;
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_rsp: got valid=%b out=%h want 0/00", rsp_valid, rsp_out);
        end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_readys: got %b want 00", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_rsp: got %0d valid cycles want 0", seen);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL mid_reset_grant: got %b want 01", {req1_ready, req0_ready});
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_alternate();
        test_saturate();
        test_pass();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
